// File: rtl/bram_pkg.sv
// Shared definitions for the simple-dual-port byte-enabled BRAM.
//   RDW_OLD / RDW_NEW : encodings for the RdwNewData parameter
//   clr_state_e       : states of the clear sequencer (idle / clearing)
package bram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/sdp_bram_core.sv
// Bare byte-enabled storage array with one write port and one registered
// read port. Neither the array nor the read register is reset, so synthesis
// can map the whole thing onto a block RAM primitive.
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe (caller guarantees address in range)
//   wr_addr_i  write word address
//   wr_be_i    byte enables, bit k covers wr_data_i[8k+7:8k]
//   wr_data_i  write data
//   rd_en_i    read strobe (caller guarantees address in range)
//   rd_addr_i  read word address
//   rd_data_o  registered read data, holds while rd_en_i is low
module sdp_bram_core
  import bram_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int AddrWidth = 10
) (
  input  logic                   clk_i,
  input  logic                   wr_en_i,
  input  logic [AddrWidth-1:0]   wr_addr_i,
  input  logic [DataWidth/8-1:0] wr_be_i,
  input  logic [DataWidth-1:0]   wr_data_i,
  input  logic                   rd_en_i,
  input  logic [AddrWidth-1:0]   rd_addr_i,
  output logic [DataWidth-1:0]   rd_data_o
);

  localparam int NumBytes = DataWidth / 8;

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wr_be_i[b]) begin
          mem[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Read-before-write: a same-address write in the same cycle is not seen
  // here; the top adds the bypass when new-data behaviour is wanted.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/sdp_bram_be.sv
// Simple-dual-port block RAM with byte-enabled writes, a valid-strobed read
// port, optional output register, selectable read-during-write policy and a
// clear sequencer that fills the array with ClearValue.
// Ports:
//   clk_i      clock, all logic on rising edge
//   rst_ni     asynchronous active-low reset
//   clear_i    single-cycle pulse, starts a clear (ignored while clearing)
//   ready_o    high when the array is accessible
//   wr_en_i / wr_addr_i / wr_be_i / wr_data_i   write port
//   rd_en_i / rd_addr_i                         read request
//   rd_data_o  read data, held until the next valid read
//   rd_valid_o one-cycle strobe marking rd_data_o as new
module sdp_bram_be
  import bram_pkg::*;
#(
  parameter int                   DataWidth    = 32,
  parameter int                   Depth        = 1024,
  parameter bit                   OutReg       = 1'b0,
  parameter int                   RdwNewData   = RDW_OLD,
  parameter logic [DataWidth-1:0] ClearValue   = '0,
  parameter bit                   ClearOnReset = 1'b1,
  localparam int                  AddrWidth    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  output logic                   ready_o,
  input  logic                   wr_en_i,
  input  logic [AddrWidth-1:0]   wr_addr_i,
  input  logic [DataWidth/8-1:0] wr_be_i,
  input  logic [DataWidth-1:0]   wr_data_i,
  input  logic                   rd_en_i,
  input  logic [AddrWidth-1:0]   rd_addr_i,
  output logic [DataWidth-1:0]   rd_data_o,
  output logic                   rd_valid_o
);

  localparam int                   NumBytes = DataWidth / 8;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  clr_state_e           state_reg, state_next;
  logic [AddrWidth-1:0] clr_addr_reg, clr_addr_next;

  logic ready;
  logic wr_in_range, rd_in_range;
  logic wr_ok, rd_ok, collide;

  logic                 core_wr_en;
  logic [AddrWidth-1:0] core_wr_addr;
  logic [NumBytes-1:0]  core_wr_be;
  logic [DataWidth-1:0] core_wr_data;
  logic [DataWidth-1:0] core_rd_data;

  logic                 s1_valid_reg;
  logic                 s1_seen_reg;
  logic                 s1_oob_reg;
  logic [NumBytes-1:0]  s1_mask_reg;
  logic [DataWidth-1:0] s1_byp_reg;
  logic [DataWidth-1:0] s1_bits;
  logic [DataWidth-1:0] s1_data;

  // ---------------------------------------------------------------- clear FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ClearOnReset ? ST_CLEAR : ST_IDLE;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clear_i) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_reg == LastAddr) begin
          state_next = ST_IDLE;
        end else begin
          clr_addr_next = clr_addr_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ready   = (state_reg == ST_IDLE);
  assign ready_o = ready;

  // ------------------------------------------------------------ range checks
  // With a power-of-two depth every address is legal; the explicit compare
  // only exists when the address space has holes.
  if (Depth == (1 << AddrWidth)) begin : g_pow2
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_npow2
    assign wr_in_range = (32'(wr_addr_i) < 32'(Depth));
    assign rd_in_range = (32'(rd_addr_i) < 32'(Depth));
  end

  assign wr_ok   = wr_en_i && ready && wr_in_range;
  assign rd_ok   = rd_en_i && ready;
  assign collide = (RdwNewData == RDW_NEW) && wr_ok && rd_ok && (wr_addr_i == rd_addr_i);

  // The clear sequencer owns the write port while clearing; user writes are
  // already blocked by ready being low.
  always_comb begin
    core_wr_en   = wr_ok;
    core_wr_addr = wr_addr_i;
    core_wr_be   = wr_be_i;
    core_wr_data = wr_data_i;
    if (state_reg == ST_CLEAR) begin
      core_wr_en   = 1'b1;
      core_wr_addr = clr_addr_reg;
      core_wr_be   = '1;
      core_wr_data = ClearValue;
    end
  end

  sdp_bram_core #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .AddrWidth (AddrWidth)
  ) u_core (
    .clk_i     (clk_i),
    .wr_en_i   (core_wr_en),
    .wr_addr_i (core_wr_addr),
    .wr_be_i   (core_wr_be),
    .wr_data_i (core_wr_data),
    .rd_en_i   (rd_ok && rd_in_range),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (core_rd_data)
  );

  // ------------------------------------------------------- read stage 1
  // Side-band registers travel alongside the RAM read register: the bypass
  // byte mask/data for collisions, an out-of-range flag that forces zero,
  // and a "seen" flag so the output reads zero before the first read even
  // though the RAM register itself is never reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_reg <= 1'b0;
      s1_seen_reg  <= 1'b0;
      s1_oob_reg   <= 1'b0;
      s1_mask_reg  <= '0;
      s1_byp_reg   <= '0;
    end else begin
      s1_valid_reg <= rd_ok;
      if (rd_ok) begin
        s1_seen_reg <= 1'b1;
        s1_oob_reg  <= !rd_in_range;
        s1_mask_reg <= collide ? wr_be_i : '0;
        s1_byp_reg  <= wr_data_i;
      end
    end
  end

  for (genvar gi = 0; gi < NumBytes; gi++) begin : g_mask
    assign s1_bits[gi*8 +: 8] = {8{s1_mask_reg[gi]}};
  end

  assign s1_data = (!s1_seen_reg || s1_oob_reg) ? '0
                 : ((core_rd_data & ~s1_bits) | (s1_byp_reg & s1_bits));

  // ------------------------------------------------------- output stage
  if (OutReg) begin : g_outreg
    logic [DataWidth-1:0] out_data_reg;
    logic                 out_valid_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_data_reg  <= '0;
        out_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_data_reg <= s1_data;
        end
      end
    end

    assign rd_data_o  = out_data_reg;
    assign rd_valid_o = out_valid_reg;
  end else begin : g_noreg
    assign rd_data_o  = s1_data;
    assign rd_valid_o = s1_valid_reg;
  end

  // ------------------------------------------------------- sim-only checks
  always_ff @(posedge clk_i) begin
    if (rst_ni && ready && wr_en_i) begin
      assert (wr_in_range)
        else $warning("sdp_bram_be: write to address %0d beyond depth %0d dropped", wr_addr_i, Depth);
    end
    if (rst_ni && ready && rd_en_i) begin
      assert (rd_in_range)
        else $warning("sdp_bram_be: read from address %0d beyond depth %0d returns zero", rd_addr_i, Depth);
    end
  end

endmodule

// File: tb/tb_sdp_bram_be.sv
// Bench for sdp_bram_be. Two instances share one stimulus stream:
//   dut_a: Depth 16, OutReg 0, old-data collisions, ClearValue A5A5A5A5
//   dut_b: Depth 10, OutReg 1, new-data collisions, ClearValue 5A5A0F0F
// A behavioural model per instance pushes expected read words (with the
// cycle they are due) into a queue when the read is issued; they are popped
// and compared when the DUT strobes rd_valid_o.
module tb_sdp_bram_be;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        ready_a, ready_b, valid_a, valid_b;
  logic [31:0] data_a, data_b;

  always #5 clk = ~clk;

  sdp_bram_be #(
    .DataWidth(32), .Depth(16), .OutReg(1'b0), .RdwNewData(0),
    .ClearValue(32'hA5A5_A5A5), .ClearOnReset(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .ready_o(ready_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(data_a), .rd_valid_o(valid_a)
  );

  sdp_bram_be #(
    .DataWidth(32), .Depth(10), .OutReg(1'b1), .RdwNewData(1),
    .ClearValue(32'h5A5A_0F0F), .ClearOnReset(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .ready_o(ready_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(data_b), .rd_valid_o(valid_b)
  );

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  int          depth_m [2] = '{16, 10};
  int          lat_m   [2] = '{1, 2};
  bit          rdw_m   [2] = '{1'b0, 1'b1};
  logic [31:0] cv_m    [2] = '{32'hA5A5_A5A5, 32'h5A5A_0F0F};
  logic [31:0] mem_m   [2][16];
  bit          mclr    [2];
  int          maddr   [2];
  exp_t        sb_a[$];
  exp_t        sb_b[$];

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
  endtask

  task automatic model_reset();
    mclr  = '{1'b1, 1'b1};
    maddr = '{0, 0};
    sb_a.delete();
    sb_b.delete();
  endtask

  task automatic model_edge(input int i);
    logic [31:0] d;
    exp_t        e;
    if (!rst_n) return;
    if (mclr[i]) begin
      mem_m[i][maddr[i]] = cv_m[i];
      if (maddr[i] == depth_m[i] - 1) mclr[i] = 1'b0;
      else maddr[i]++;
    end else begin
      if (rd_en) begin
        d = (int'(rd_addr) < depth_m[i]) ? mem_m[i][rd_addr] : 32'h0;
        if (rdw_m[i] && wr_en && (wr_addr == rd_addr) && (int'(wr_addr) < depth_m[i]))
          d = merge(d, wr_data, wr_be);
        e.d   = d;
        e.due = cyc + lat_m[i] - 1;
        if (i == 0) sb_a.push_back(e);
        else        sb_b.push_back(e);
      end
      if (wr_en && (int'(wr_addr) < depth_m[i]))
        mem_m[i][wr_addr] = merge(mem_m[i][wr_addr], wr_data, wr_be);
      if (clear) begin
        mclr[i]  = 1'b1;
        maddr[i] = 0;
      end
    end
  endtask

  task automatic check_out(input int i);
    logic        rdy, vld;
    logic [31:0] dat;
    exp_t        e;
    bit          due;
    string       nm;
    nm  = (i == 0) ? "a" : "b";
    rdy = (i == 0) ? ready_a : ready_b;
    vld = (i == 0) ? valid_a : valid_b;
    dat = (i == 0) ? data_a  : data_b;
    chk({nm, "_ready"}, 32'(rdy), 32'(!mclr[i]));
    if (i == 0) due = (sb_a.size() > 0) && (sb_a[0].due == cyc);
    else        due = (sb_b.size() > 0) && (sb_b[0].due == cyc);
    chk({nm, "_valid"}, 32'(vld), 32'(due));
    if (due) begin
      e = (i == 0) ? sb_a.pop_front() : sb_b.pop_front();
      if (vld) chk({nm, "_data"}, dat, e.d);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check_out(0);
    check_out(1);
  endtask

  task automatic drive(input bit we, input logic [3:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input bit re, input logic [3:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra;
    cycle();
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0; wr_be = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic sweep();
    for (int a = 0; a < 16; a++) drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
    idle(3);
  endtask

  task automatic chk_reset_outputs();
    chk("a_rst_data", data_a, 32'h0);
    chk("a_rst_valid", 32'(valid_a), 32'h0);
    chk("a_rst_ready", 32'(ready_a), 32'h0);
    chk("b_rst_data", data_b, 32'h0);
    chk("b_rst_valid", 32'(valid_b), 32'h0);
    chk("b_rst_ready", 32'(ready_b), 32'h0);
  endtask

  // Counts ready-low cycles starting from the current sample; bounded so a
  // stuck sequencer shows up as a wrong length instead of a hang.
  task automatic measure_clear(input bit traffic);
    int la, lb;
    la = ready_a ? 0 : 1;
    lb = ready_b ? 0 : 1;
    for (int k = 0; k < 24; k++) begin
      if (traffic && k < 8) begin
        wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 15)); wr_be = 4'hF;
        wr_data = $urandom; rd_en = 1'b1; rd_addr = 4'($urandom_range(0, 15));
      end else begin
        wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
      end
      cycle();
      if (!ready_a) la++;
      if (!ready_b) lb++;
    end
    chk("a_clear_len", 32'(la), 32'd16);
    chk("b_clear_len", 32'(lb), 32'd10);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    model_reset();
    repeat (2) cycle();
    chk_reset_outputs();

    // Clear after reset, then every location holds ClearValue.
    rst_n = 1'b1;
    measure_clear(1'b0);
    sweep();

    // Byte-enabled partial write over a full write.
    drive(1'b1, 4'd5, 4'hF, 32'hDEAD_BEEF, 1'b0, 4'd0);
    drive(1'b1, 4'd5, 4'h1, 32'h0000_00AA, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd5);
    idle(3);

    // Same-address collision, then a plain read of the merged word.
    drive(1'b1, 4'd3, 4'hF, 32'h1111_1111, 1'b0, 4'd0);
    drive(1'b1, 4'd3, 4'h3, 32'h2222_2222, 1'b1, 4'd3);
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd3);
    idle(3);

    // Independent write and read on different addresses, zero byte enables.
    drive(1'b1, 4'd7, 4'hF, 32'h1234_5678, 1'b1, 4'd5);
    drive(1'b1, 4'd7, 4'h0, 32'hFFFF_FFFF, 1'b1, 4'd7);
    idle(3);

    // Address 12 is beyond dut_b's depth: write dropped, read returns zero.
    drive(1'b1, 4'd12, 4'hF, 32'hFFFF_FFFF, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd12);
    idle(3);
    sweep();

    // Clear request with traffic during the window.
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd5);
    clear = 1'b1;
    drive(1'b1, 4'd1, 4'hF, 32'h0BAD_F00D, 1'b1, 4'd1);
    clear = 1'b0;
    measure_clear(1'b1);
    sweep();

    // Reset asserted while clearing address 7.
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd5);
    idle(2);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    repeat (7) cycle();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    measure_clear(1'b0);
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
